// File: rtl/aes_spi_host_seq.sv
// Purpose: sequences key, then data, as WORD_W words into an SPI master and assembles the returned words into a block.
// Latency: start -> first spi_tx_valid in 2 cycles; result_valid 1 cycle after the last receive done.
// Backpressure: spi_tx_valid is held until the master drops spi_cs; start is ignored while busy.
module aes_spi_host_seq #(
  parameter int WORD_W  = 16,
  parameter int BLOCK_W = 128,
  parameter int RX_SKIP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode_in,
  input  logic [BLOCK_W-1:0] key_in,
  input  logic [BLOCK_W-1:0] text_in,
  output logic               mode_out,
  output logic               busy,
  output logic [BLOCK_W-1:0] result,
  output logic               result_valid,
  input  logic               spi_cs,
  input  logic               spi_done,
  input  logic [WORD_W-1:0]  spi_rx,
  output logic [WORD_W-1:0]  spi_tx,
  output logic               spi_tx_valid
);

  localparam int NWORDS = BLOCK_W / WORD_W;
  localparam int CNT_W  = 4;

  // Counter limits; RX_SKIP + NWORDS must stay within the 4-bit counter range.
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TX_WORDS = CNT_W'(NWORDS);
  localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(NWORDS - 1);
  localparam logic [CNT_W-1:0] RX_FIRST = CNT_W'(RX_SKIP);
  localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(RX_SKIP + NWORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    GAP,
    TEXT,
    RECV,
    FINISH
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               tx_ok;
  logic [BLOCK_W-1:0] key_sr;
  logic [BLOCK_W-1:0] text_sr;

  // Saturating counter increment and "master idle, words remain" request condition.
  always_comb begin
    cnt_inc = cnt;
    if (cnt != CNT_SAT) begin
      cnt_inc = cnt + CNT_ONE;
    end
    tx_ok = spi_cs && (cnt < TX_WORDS);
  end

  // Sequencer FSM; every output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      key_sr       <= '0;
      text_sr      <= '0;
      mode_out     <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      spi_tx       <= '0;
      spi_tx_valid <= 1'b0;
    end else begin
      // result_valid is a single-cycle pulse raised only on entry to FINISH.
      result_valid <= 1'b0;

      case (state)
        IDLE: begin
          spi_tx_valid <= 1'b0;
          if (start) begin
            // The first key word goes straight to spi_tx; key_sr keeps the remainder.
            key_sr   <= key_in >> WORD_W;
            text_sr  <= text_in;
            mode_out <= mode_in;
            result   <= '0;
            busy     <= 1'b1;
            cnt      <= '0;
            spi_tx   <= key_in[WORD_W-1:0];
            state    <= KEY;
          end
        end

        KEY: begin
          if (spi_done) begin
            if (cnt == TX_LAST) begin
              // Stage the first text word so it is already on spi_tx during GAP.
              cnt          <= '0;
              spi_tx_valid <= 1'b0;
              spi_tx       <= text_sr[WORD_W-1:0];
              text_sr      <= text_sr >> WORD_W;
              state        <= GAP;
            end else begin
              cnt    <= cnt_inc;
              spi_tx <= key_sr[WORD_W-1:0];
              key_sr <= key_sr >> WORD_W;
            end
          end else if (!spi_cs) begin
            spi_tx_valid <= 1'b0;
          end else if (tx_ok) begin
            spi_tx_valid <= 1'b1;
          end
        end

        GAP: begin
          // The GAP cycle itself shows valid low; the request may rise again in the first TEXT cycle.
          spi_tx_valid <= tx_ok;
          state        <= TEXT;
        end

        TEXT: begin
          if (spi_done) begin
            if (cnt == TX_LAST) begin
              cnt          <= '0;
              spi_tx_valid <= 1'b0;
              spi_tx       <= '0;
              state        <= RECV;
            end else begin
              cnt     <= cnt_inc;
              spi_tx  <= text_sr[WORD_W-1:0];
              text_sr <= text_sr >> WORD_W;
            end
          end else if (!spi_cs) begin
            spi_tx_valid <= 1'b0;
          end else if (tx_ok) begin
            spi_tx_valid <= 1'b1;
          end
        end

        RECV: begin
          // Dummy words keep the master clocking so the slave can return its block.
          spi_tx <= '0;
          if (spi_done) begin
            cnt <= cnt_inc;
            // The first RX_SKIP words are slave latency and are dropped.
            if (cnt >= RX_FIRST) begin
              result <= {spi_rx, result[BLOCK_W-1:WORD_W]};
            end
            if (cnt == RX_LAST) begin
              cnt          <= '0;
              spi_tx_valid <= 1'b0;
              result_valid <= 1'b1;
              state        <= FINISH;
            end else begin
              spi_tx_valid <= 1'b1;
            end
          end else begin
            spi_tx_valid <= 1'b1;
          end
        end

        FINISH: begin
          spi_tx_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end

        default: begin
          spi_tx_valid <= 1'b0;
          busy         <= 1'b0;
          cnt          <= '0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_spi_host_seq.sv
// Bench for aes_spi_host_seq: a mock SPI master answers requests, a monitor scores tx words and results.
// Expected words and results are queued when each operation is issued and are popped on DUT events.
// Covers reset values, word order, GAP, dropped latency word, abort by reset, and start during RECV.
module tb_aes_spi_host_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         mode_in;
  logic [127:0] key_in;
  logic [127:0] text_in;
  logic         mode_out;
  logic         busy;
  logic [127:0] result;
  logic         result_valid;
  logic         spi_cs;
  logic         spi_done;
  logic [15:0]  spi_rx;
  logic [15:0]  spi_tx;
  logic         spi_tx_valid;

  typedef struct packed {
    logic [127:0] res;
    logic         mode;
  } exp_res_t;

  logic [15:0] exp_tx[$];
  logic [15:0] rx_q[$];
  exp_res_t    exp_res[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  logic inject = 1'b0;
  logic mm_inj = 1'b0;

  localparam logic [127:0] PAT_KEY  = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
  localparam logic [127:0] PAT_TEXT = 128'h000f_000e_000d_000c_000b_000a_0009_0008;
  localparam logic [143:0] PAT_RX   = {16'h0008, 16'h0007, 16'h0006, 16'h0005, 16'h0004,
                                       16'h0003, 16'h0002, 16'h0001, 16'haaaa};
  localparam logic [127:0] PAT_RES  = 128'h0008_0007_0006_0005_0004_0003_0002_0001;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [143:0] RX_PT    = {16'h3243, 16'hf6a8, 16'h885a, 16'h308d, 16'h3131,
                                       16'h98a2, 16'he037, 16'h0734, 16'h1234};
  localparam logic [143:0] RX_CT    = {16'h3925, 16'h841d, 16'h02dc, 16'h09fb, 16'hdc11,
                                       16'h8597, 16'h196a, 16'h0b32, 16'hffff};

  aes_spi_host_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mode_in      (mode_in),
    .key_in       (key_in),
    .text_in      (text_in),
    .mode_out     (mode_out),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .spi_cs       (spi_cs),
    .spi_done     (spi_done),
    .spi_rx       (spi_rx),
    .spi_tx       (spi_tx),
    .spi_tx_valid (spi_tx_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string got, input string exp);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %s, expected %s", name, got, exp);
  endtask

  // Stimulus acts 2 time units after the rising edge; the mock acts at 1, the monitor on the falling edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Mock SPI master: accepts a word when valid and idle, drops cs for 3 cycles, then pulses done.
  task automatic mock_loop();
    int   left = 0;
    int   n = 0;
    logic xfer = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      spi_done = 1'b0;
      mm_inj   = 1'b0;
      if (!rst_n) begin
        spi_cs = 1'b1;
        xfer   = 1'b0;
        left   = 0;
        n      = 0;
        rx_q.delete();
      end else if (xfer) begin
        left--;
        if (left == 0) begin
          xfer     = 1'b0;
          spi_cs   = 1'b1;
          spi_done = 1'b1;
          if (n >= 16) begin
            if (rx_q.size() > 0) spi_rx = rx_q.pop_front();
            else spi_rx = 16'hbad0;
          end else begin
            spi_rx = 16'h5a5a;
          end
          n = (n == 24) ? 0 : n + 1;
        end
      end else if (inject) begin
        spi_done = 1'b1;
        mm_inj   = 1'b1;
        spi_rx   = 16'hdead;
      end else if (spi_tx_valid && spi_cs) begin
        xfer   = 1'b1;
        spi_cs = 1'b0;
        left   = 3;
      end
    end
  endtask

  // Monitor: scores each transferred word, the GAP cycle and each result_valid against the queues.
  task automatic monitor_loop();
    int          nd = 0;
    int          gap = 0;
    exp_res_t    e;
    logic [15:0] w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_tx.delete();
        exp_res.delete();
        nd  = 0;
        gap = 0;
      end else begin
        if (gap == 2) begin
          check("first_text_cycle_valid", 128'(spi_tx_valid), 128'd1);
          gap = 0;
        end
        if (gap == 1) begin
          check("gap_valid_low", 128'(spi_tx_valid), 128'd0);
          if (exp_tx.size() > 0) check("gap_tx_text_word0", 128'(spi_tx), 128'(exp_tx[0]));
          gap = 2;
        end
        if (spi_done && !mm_inj) begin
          if (exp_tx.size() == 0) begin
            fail_now("unexpected_done", "extra transfer", "no transfer");
          end else begin
            w = exp_tx.pop_front();
            check($sformatf("tx_word%0d", nd), 128'(spi_tx), 128'(w));
          end
          nd = (nd == 24) ? 0 : nd + 1;
          if (nd == 8) gap = 1;
        end
        if (result_valid) begin
          if (exp_res.size() == 0) begin
            fail_now("unexpected_result_valid", "pulse", "no pulse");
          end else begin
            e = exp_res.pop_front();
            check("result", result, e.res);
            check("mode_out", 128'(mode_out), 128'(e.mode));
            check("busy_at_result_valid", 128'(busy), 128'd1);
          end
        end
      end
    end
  endtask

  task automatic issue_op(input logic [127:0] k, input logic [127:0] t, input logic m,
                          input logic [143:0] rxw, input logic [127:0] exp_r);
    exp_res_t e;
    for (int i = 0; i < 8; i++) exp_tx.push_back(k[16*i +: 16]);
    for (int i = 0; i < 8; i++) exp_tx.push_back(t[16*i +: 16]);
    for (int i = 0; i < 9; i++) exp_tx.push_back(16'h0000);
    for (int i = 0; i < 9; i++) rx_q.push_back(rxw[16*i +: 16]);
    e.res  = exp_r;
    e.mode = m;
    exp_res.push_back(e);
    key_in  = k;
    text_in = t;
    mode_in = m;
    start   = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", 128'(busy), 128'd1);
    check("result_cleared_on_start", result, 128'd0);
    check("tx_first_key_word", 128'(spi_tx), 128'(k[15:0]));
  endtask

  task automatic wait_idle(input int limit);
    int t = 0;
    while (busy && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (busy) fail_now("op_timeout", "busy stuck high", "busy low");
    repeat (3) step();
  endtask

  task automatic wait_dones(input int n, input int limit);
    int seen = 0;
    int t = 0;
    while (seen < n && t < limit) begin
      @(negedge clk);
      t++;
      if (spi_done && !mm_inj) seen++;
    end
    if (seen < n) fail_now($sformatf("wait_%0d_dones_timeout", n), "too few dones", "enough dones");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_spi_tx"}, 128'(spi_tx), 128'd0);
    check({tag, "_spi_tx_valid"}, 128'(spi_tx_valid), 128'd0);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_result"}, result, 128'd0);
    check({tag, "_result_valid"}, 128'(result_valid), 128'd0);
    check({tag, "_mode_out"}, 128'(mode_out), 128'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    mode_in  = 1'b0;
    key_in   = '0;
    text_in  = '0;
    spi_cs   = 1'b1;
    spi_done = 1'b0;
    spi_rx   = '0;
    fork
      mock_loop();
      monitor_loop();
    join_none

    // Reset values
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Word order, GAP and dropped latency word
    issue_op(PAT_KEY, PAT_TEXT, 1'b0, PAT_RX, PAT_RES);
    wait_idle(2000);

    // FIPS-197 decrypt vector through the mock
    issue_op(FIPS_KEY, FIPS_CT, 1'b1, RX_PT, FIPS_PT);
    wait_idle(2000);

    // A done pulse while idle must change nothing
    inject = 1'b1;
    step();
    inject = 1'b0;
    repeat (3) step();
    check("idle_done_busy", 128'(busy), 128'd0);
    check("idle_done_valid", 128'(spi_tx_valid), 128'd0);
    check("idle_done_result_held", result, FIPS_PT);

    // FIPS-197 encrypt vector
    issue_op(FIPS_KEY, FIPS_PT, 1'b0, RX_CT, FIPS_CT);
    wait_idle(2000);

    // Reset after the 3rd text word aborts cleanly
    issue_op(FIPS_KEY, FIPS_CT, 1'b1, RX_PT, FIPS_PT);
    wait_dones(11, 2000);
    step();
    rst_n = 1'b0;
    #1;
    check_all_zero("abort_async");
    @(negedge clk);
    check_all_zero("abort_edge");
    repeat (2) step();
    rst_n = 1'b1;
    step();
    issue_op(PAT_KEY, PAT_TEXT, 1'b0, PAT_RX, PAT_RES);
    wait_idle(2000);

    // start during RECV is ignored
    issue_op(FIPS_KEY, FIPS_CT, 1'b1, RX_PT, FIPS_PT);
    wait_dones(18, 2000);
    step();
    key_in  = PAT_KEY;
    text_in = PAT_TEXT;
    mode_in = 1'b0;
    start   = 1'b1;
    step();
    start = 1'b0;
    check("busy_during_ignored_start", 128'(busy), 128'd1);
    wait_idle(2000);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("busy_stays_low", 128'(busy), 128'd0);
    end
    check("result_after_ignored_start", result, FIPS_PT);
    check("mode_after_ignored_start", 128'(mode_out), 128'd1);

    check("exp_tx_drained", 128'(exp_tx.size()), 128'd0);
    check("exp_res_drained", 128'(exp_res.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
